// File: rtl/binary_counter_pkg.sv
// Shared constants and helpers for the presettable binary down-counter.
// The counter is built from SLICE_W-bit slices chained by their zero flags.
package binary_counter_pkg;

    localparam int unsigned SLICE_W = 4;

    function automatic logic is_zero(input logic [SLICE_W-1:0] vec);
        return (vec == '0);
    endfunction

endpackage

// File: rtl/down_counter_slice.sv
// One 4-bit down-counting slice with async clear, sync parallel load and count enable.
// ZERO reports the slice's own terminal count for the borrow chain.
module down_counter_slice
    import binary_counter_pkg::*;
(
    input  logic               CLK,
    input  logic               CLR,
    input  logic               LOAD_n,
    input  logic [SLICE_W-1:0] D,
    input  logic               CE_IN,
    output logic [SLICE_W-1:0] Q,
    output logic               ZERO
);

    localparam logic [SLICE_W-1:0] SliceOne = SLICE_W'(1);

    logic [SLICE_W-1:0] cnt_q;
    logic [SLICE_W-1:0] cnt_d;

    // Load outranks count, so a simultaneous request never decrements.
    always_comb begin
        cnt_d = cnt_q;
        if (!LOAD_n) begin
            cnt_d = D;
        end else if (CE_IN) begin
            cnt_d = cnt_q - SliceOne;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Q    = cnt_q;
    assign ZERO = is_zero(cnt_q);

endmodule

// File: rtl/binary_down_counter.sv
// Presettable binary down-counter with ripple-borrow out, built from 4-bit slices.
// Define BDC_AUTO_RELOAD_EN to reload the last loaded value instead of wrapping at zero.
module binary_down_counter
    import binary_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             LOAD_n,
    input  logic [WIDTH-1:0] D,
    input  logic             ENP,
    input  logic             ENT,
    output logic [WIDTH-1:0] Q,
    output logic             RBO
);

    localparam int unsigned NSLICE = WIDTH / SLICE_W;

    if ((WIDTH % SLICE_W) != 0 || WIDTH == 0) begin : g_width_check
        $error("binary_down_counter: WIDTH must be a non-zero multiple of 4");
    end

    logic              count_en;
    logic              all_zero;
    logic [NSLICE:0]   lower_zero;
    logic [NSLICE-1:0] slice_zero;
    logic [NSLICE-1:0] slice_ce;
    logic              slice_load_n;
    logic [WIDTH-1:0]  slice_d;

    assign count_en = ENP & ENT;

    // Slice k borrows only when every less significant slice sits at zero.
    always_comb begin
        lower_zero    = '0;
        slice_ce      = '0;
        lower_zero[0] = 1'b1;
        for (int unsigned k = 0; k < NSLICE; k++) begin
            slice_ce[k]     = count_en & lower_zero[k];
            lower_zero[k+1] = lower_zero[k] & slice_zero[k];
        end
    end

    assign all_zero = lower_zero[NSLICE];

`ifdef BDC_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;

    always_comb begin
        reload_d = reload_q;
        if (!LOAD_n) begin
            reload_d = D;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end

    // Counting out of zero becomes an internal load of the reload value.
    always_comb begin
        slice_load_n = LOAD_n & ~(count_en & all_zero);
        slice_d      = LOAD_n ? reload_q : D;
    end
`else
    always_comb begin
        slice_load_n = LOAD_n;
        slice_d      = D;
    end
`endif

    for (genvar k = 0; k < NSLICE; k++) begin : g_slice
        down_counter_slice u_slice (
            .CLK    (CLK),
            .CLR    (CLR),
            .LOAD_n (slice_load_n),
            .D      (slice_d[k*SLICE_W +: SLICE_W]),
            .CE_IN  (slice_ce[k]),
            .Q      (Q[k*SLICE_W +: SLICE_W]),
            .ZERO   (slice_zero[k])
        );
    end

    assign RBO = ENT & all_zero;

endmodule

// File: tb/tb_binary_down_counter.sv
// Bench for binary_down_counter: a 4-bit and an 8-bit instance checked against an
// arithmetic model of load / decrement / wrap-or-reload behaviour.
module tb_binary_down_counter;

`ifdef BDC_AUTO_RELOAD_EN
    localparam bit AutoReload = 1'b1;
`else
    localparam bit AutoReload = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic       load4_n, enp4, ent4;
    logic [3:0] d4, q4;
    logic       rbo4;
    logic       load8_n, enp8, ent8;
    logic [7:0] d8, q8;
    logic       rbo8;

    int checks = 0;
    int errors = 0;
    int m4, r4, m8, r8;

    always #5 clk = ~clk;

    binary_down_counter #(.WIDTH(4)) dut4 (
        .CLK(clk), .CLR(clr), .LOAD_n(load4_n), .D(d4),
        .ENP(enp4), .ENT(ent4), .Q(q4), .RBO(rbo4)
    );

    binary_down_counter #(.WIDTH(8)) dut8 (
        .CLK(clk), .CLR(clr), .LOAD_n(load8_n), .D(d8),
        .ENP(enp8), .ENT(ent8), .Q(q8), .RBO(rbo8)
    );

    function automatic int next_val(int q, int r, int d, bit ld, bit en, int modulus);
        if (ld) return d;
        if (!en) return q;
        if (q == 0) return AutoReload ? r : modulus - 1;
        return q - 1;
    endfunction

    task automatic clear_model();
        m4 = 0; r4 = 0; m8 = 0; r8 = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (clr) begin
            clear_model();
        end else begin
            m4 = next_val(m4, r4, int'(d4), !load4_n, enp4 && ent4, 16);
            if (!load4_n) r4 = int'(d4);
            m8 = next_val(m8, r8, int'(d8), !load8_n, enp8 && ent8, 256);
            if (!load8_n) r8 = int'(d8);
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        load4_n = 1'b1; enp4 = 1'b0; ent4 = 1'b0; d4 = '0;
        load8_n = 1'b1; enp8 = 1'b0; ent8 = 1'b0; d8 = '0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        idle_inputs();
        clear_model();
        #1;
        checks++;
        if (q4 !== 4'd0 || q8 !== 8'd0) begin
            errors++;
            $display("FAIL reset_q: got q4=%0d q8=%0d, want 0/0", q4, q8);
        end
        @(negedge clk);
        clr = 1'b0;
        // Load 9, then clear 2 ns into a cycle and look before the next edge.
        d4 = 4'd9; load4_n = 1'b0;
        tick();
        load4_n = 1'b1;
        checks++;
        if (q4 !== 4'd9) begin
            errors++;
            $display("FAIL reset_preload: got %0d, want 9", q4);
        end
        #2 clr = 1'b1;
        clear_model();
        #1;
        checks++;
        if (q4 !== 4'd0) begin
            errors++;
            $display("FAIL reset_async: got %0d, want 0 before edge", q4);
        end
        tick();
        clr = 1'b0;
        checks++;
        if (q4 !== 4'd0) begin
            errors++;
            $display("FAIL reset_hold: got %0d, want 0", q4);
        end
    endtask

    task automatic test_load_priority();
        int exp_seq [3] = '{1, 0, 15};
        d4 = 4'd2; load4_n = 1'b0; enp4 = 1'b1; ent4 = 1'b1;
        tick();
        checks++;
        if (q4 !== 4'd2 || int'(q4) != m4) begin
            errors++;
            $display("FAIL load_priority: got %0d, want 2", q4);
        end
        load4_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (int'(q4) != m4 || (!AutoReload && int'(q4) != exp_seq[i])) begin
                errors++;
                $display("FAIL load_then_count[%0d]: got %0d, want %0d", i, q4, m4);
            end
        end
    endtask

    task automatic test_enable_gating();
        d4 = 4'd0; load4_n = 1'b0;
        tick();
        load4_n = 1'b1; enp4 = 1'b0; ent4 = 1'b1;
        tick();
        checks++;
        if (q4 !== 4'd0 || rbo4 !== 1'b1) begin
            errors++;
            $display("FAIL gate_enp_low: got q=%0d rbo=%b, want q=0 rbo=1", q4, rbo4);
        end
        enp4 = 1'b1; ent4 = 1'b0;
        #1;
        checks++;
        if (rbo4 !== 1'b0) begin
            errors++;
            $display("FAIL gate_ent_rbo: got rbo=%b, want 0", rbo4);
        end
        tick();
        checks++;
        if (q4 !== 4'd0 || int'(q4) != m4) begin
            errors++;
            $display("FAIL gate_ent_hold: got %0d, want 0", q4);
        end
    endtask

    task automatic test_cascade();
        enp4 = 1'b0; ent4 = 1'b0;
        d8 = 8'h10; load8_n = 1'b0; enp8 = 1'b1; ent8 = 1'b1;
        tick();
        load8_n = 1'b1;
        tick();
        checks++;
        if (q8 !== 8'h0F || int'(q8) != m8) begin
            errors++;
            $display("FAIL cascade_borrow: got %h, want 0f", q8);
        end
        d8 = 8'h00; load8_n = 1'b0;
        tick();
        load8_n = 1'b1;
        checks++;
        if (q8 !== 8'h00 || rbo8 !== 1'b1) begin
            errors++;
            $display("FAIL cascade_zero_rbo: got q=%h rbo=%b, want 00/1", q8, rbo8);
        end
        ent8 = 1'b0;
        #1;
        checks++;
        if (rbo8 !== 1'b0) begin
            errors++;
            $display("FAIL cascade_rbo_ent: got rbo=%b, want 0", rbo8);
        end
        ent8 = 1'b1;
        tick();
        checks++;
        if (int'(q8) != m8 || rbo8 !== (m8 == 0) || (!AutoReload && q8 !== 8'hFF)) begin
            errors++;
            $display("FAIL cascade_wrap: got q=%h rbo=%b, want q=%h", q8, rbo8, m8[7:0]);
        end
        enp8 = 1'b0; ent8 = 1'b0;
    endtask

    task automatic test_auto_reload();
        int exp_seq [8] = '{2, 1, 0, 3, 2, 1, 0, 3};
        d4 = 4'd3; load4_n = 1'b0; enp4 = 1'b1; ent4 = 1'b1;
        tick();
        load4_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (int'(q4) != exp_seq[i] || rbo4 !== (exp_seq[i] == 0)) begin
                errors++;
                $display("FAIL auto_reload[%0d]: got q=%0d rbo=%b, want %0d", i, q4, rbo4,
                         exp_seq[i]);
            end
        end
        clr = 1'b1;
        clear_model();
        tick();
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (q4 !== 4'd0) begin
                errors++;
                $display("FAIL auto_reload_clr[%0d]: got %0d, want 0", i, q4);
            end
        end
    endtask

    task automatic test_reset_mid_count();
        d4 = 4'd5; load4_n = 1'b0; enp4 = 1'b1; ent4 = 1'b1;
        tick();
        load4_n = 1'b1;
        #2 clr = 1'b1;
        clear_model();
        #1;
        checks++;
        if (q4 !== 4'd0) begin
            errors++;
            $display("FAIL mid_count_clr: got %0d, want 0", q4);
        end
        clr = 1'b0;
        tick();
        checks++;
        if (int'(q4) != m4 || (!AutoReload && q4 !== 4'd15)) begin
            errors++;
            $display("FAIL mid_count_resume: got %0d, want %0d", q4, m4);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load4_n = ($urandom_range(0, 5) != 0);
            enp4    = ($urandom_range(0, 3) != 0);
            ent4    = ($urandom_range(0, 3) != 0);
            d4      = 4'($urandom);
            load8_n = ($urandom_range(0, 7) != 0);
            enp8    = ($urandom_range(0, 3) != 0);
            ent8    = ($urandom_range(0, 4) != 0);
            d8      = 8'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            if ($urandom_range(0, 40) == 0) begin
                clr = 1'b1;
                clear_model();
            end
            tick();
            clr = 1'b0;
            checks++;
            if (int'(q4) != m4 || rbo4 !== (ent4 && m4 == 0)) begin
                errors++;
                $display("FAIL random4[%0d]: got q=%0d rbo=%b, want q=%0d rbo=%b", i, q4, rbo4,
                         m4, ent4 && m4 == 0);
            end
            checks++;
            if (int'(q8) != m8 || rbo8 !== (ent8 && m8 == 0)) begin
                errors++;
                $display("FAIL random8[%0d]: got q=%0d rbo=%b, want q=%0d rbo=%b", i, q8, rbo8,
                         m8, ent8 && m8 == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_priority();
        test_enable_gating();
        test_cascade();
        if (AutoReload) test_auto_reload();
        test_reset_mid_count();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
